// File: rtl/adder_sum_stage.sv
// Final sum stage of a parallel-prefix adder: two-stage valid/ready pipeline.
// Optional carry/overflow/zero flags are built only when ADDER_SUM_FLAGS_EN is defined.
module adder_sum_stage #(
    parameter int LEN_DATA = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LEN_DATA-1:0] generate_in,
    input  logic [LEN_DATA-1:0] propogate_in,
    input  logic [LEN_DATA-1:0] halfsum_in,
    input  logic                carry_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LEN_DATA-1:0] sum_out,
    output logic                carry_out,
    output logic                overflow_out,
    output logic                zero_out,
    output logic                out_valid,
    input  logic                out_ready
);

    // c[0] = cin, c[i+1] = G[i:0] | (P[i:0] & cin)
    function automatic logic [LEN_DATA:0] carry_vec(
        input logic [LEN_DATA-1:0] g,
        input logic [LEN_DATA-1:0] p,
        input logic                cin
    );
        carry_vec = {g | (p & {LEN_DATA{cin}}), cin};
    endfunction

    logic                s2_free;
    logic                s1_move;
    logic                in_fire;
    logic [LEN_DATA:0]   carry_p1;

    logic                vld_p1_q, vld_p1_d;
    logic [LEN_DATA-1:0] gen_p1_q, gen_p1_d;
    logic [LEN_DATA-1:0] prop_p1_q, prop_p1_d;
    logic [LEN_DATA-1:0] hs_p1_q, hs_p1_d;
    logic                cin_p1_q, cin_p1_d;

    logic                vld_p2_q, vld_p2_d;
    logic [LEN_DATA-1:0] sum_p2_q, sum_p2_d;

    always_comb begin
        s2_free  = !vld_p2_q || out_ready;
        s1_move  = vld_p1_q && s2_free;
        in_ready = !vld_p1_q || s1_move;
        in_fire  = in_valid && in_ready;

        vld_p1_d = vld_p1_q;
        if (in_fire) begin
            vld_p1_d = 1'b1;
        end else if (s1_move) begin
            vld_p1_d = 1'b0;
        end

        gen_p1_d  = in_fire ? generate_in  : gen_p1_q;
        prop_p1_d = in_fire ? propogate_in : prop_p1_q;
        hs_p1_d   = in_fire ? halfsum_in   : hs_p1_q;
        cin_p1_d  = in_fire ? carry_in     : cin_p1_q;

        // S1 -> S2 boundary: carries resolve from the registered group terms
        carry_p1 = carry_vec(gen_p1_q, prop_p1_q, cin_p1_q);

        vld_p2_d = vld_p2_q;
        if (s1_move) begin
            vld_p2_d = 1'b1;
        end else if (out_ready) begin
            vld_p2_d = 1'b0;
        end

        sum_p2_d = s1_move ? (hs_p1_q ^ carry_p1[LEN_DATA-1:0]) : sum_p2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            sum_p2_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            sum_p2_q <= sum_p2_d;
        end
    end

    // S1 payload needs no reset: it is only consumed while vld_p1_q is set
    always_ff @(posedge clk) begin
        gen_p1_q  <= gen_p1_d;
        prop_p1_q <= prop_p1_d;
        hs_p1_q   <= hs_p1_d;
        cin_p1_q  <= cin_p1_d;
    end

    assign sum_out   = sum_p2_q;
    assign out_valid = vld_p2_q;

`ifdef ADDER_SUM_FLAGS_EN
    logic cout_p2_q, cout_p2_d;
    logic ovf_p2_q, ovf_p2_d;
    logic zero_p2_q, zero_p2_d;

    always_comb begin
        cout_p2_d = cout_p2_q;
        ovf_p2_d  = ovf_p2_q;
        zero_p2_d = zero_p2_q;
        if (s1_move) begin
            cout_p2_d = carry_p1[LEN_DATA];
            ovf_p2_d  = carry_p1[LEN_DATA] ^ carry_p1[LEN_DATA-1];
            zero_p2_d = (sum_p2_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cout_p2_q <= 1'b0;
            ovf_p2_q  <= 1'b0;
            zero_p2_q <= 1'b0;
        end else begin
            cout_p2_q <= cout_p2_d;
            ovf_p2_q  <= ovf_p2_d;
            zero_p2_q <= zero_p2_d;
        end
    end

    assign carry_out    = cout_p2_q;
    assign overflow_out = ovf_p2_q;
    assign zero_out     = zero_p2_q;
`else
    logic unused_carry_msb;
    assign unused_carry_msb = carry_p1[LEN_DATA];

    assign carry_out    = 1'b0;
    assign overflow_out = 1'b0;
    assign zero_out     = 1'b0;
`endif

endmodule

// File: doc/adder_sum_stage.md
ADDER_SUM_STAGE -- requirements
Module: adder_sum_stage

Interface
REQ-001 Parameter SHALL be: LEN_DATA, default 32, operand width; a multiple of 8, matching the prefix stages.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 generate_in  input  LEN_DATA  group generate from the last prefix stage; bit i = G[i:0].
REQ-005 propogate_in  input  LEN_DATA  group propagate from the last prefix stage; bit i = P[i:0].
REQ-006 halfsum_in  input  LEN_DATA  per-bit a^b.
REQ-007 carry_in  input  1  adder carry-in.
REQ-008 in_valid  input  1  input beat valid.
REQ-009 in_ready  output  1  block can accept a beat this cycle.
REQ-010 sum_out  output  LEN_DATA  registered sum.
REQ-011 carry_out  output  1  registered carry out of the MSB.
REQ-012 overflow_out  output  1  registered signed overflow.
REQ-013 zero_out  output  1  registered sum==0 flag.
REQ-014 out_valid  output  1  output beat valid.
REQ-015 out_ready  input  1  consumer accepts the output beat.

Function
REQ-016 Block SHALL be a 2-stage valid/ready pipeline: S1 registers inputs; S2 registers sum and flags.
REQ-017 Carry SHALL be c[0]=carry_in and c[i+1]=G[i] | (P[i] & carry_in) for i=0..LEN_DATA-1.
REQ-018 Sum SHALL be sum[i]=halfsum[i]^c[i], computed from S1 contents and loaded into S2.
REQ-019 carry_out SHALL equal c[LEN_DATA]; overflow_out SHALL equal c[LEN_DATA]^c[LEN_DATA-1]; zero_out SHALL be 1 iff the sum is all zeros.
REQ-020 A beat SHALL transfer in when in_valid && in_ready at a rising edge, and out when out_valid && out_ready.
REQ-021 S2 SHALL load from S1 when S1 is valid and S2 is either empty or transferring out in the same cycle.
REQ-022 in_ready SHALL be !s1_valid || S1 loading into S2 this cycle; a combinational out_ready->in_ready path is permitted.
REQ-023 Latency SHALL be 2 edges: a beat accepted at edge N appears with out_valid=1 after edge N+1 if not stalled.
REQ-024 Throughput SHALL be 1 beat/cycle with no bubbles while out_ready=1.
REQ-025 While out_valid=1 && out_ready=0, sum_out and all flags SHALL hold stable.
REQ-026 With both stages full and out_ready=0, in_ready SHALL be 0; no beat SHALL be dropped or duplicated.
REQ-027 Simultaneous output transfer, S1->S2 move and new input accept in one cycle SHALL be supported.
REQ-028 Wrap-around SHALL be modulo 2^LEN_DATA, with the lost carry reported only via carry_out.

Reset
REQ-029 While rst=1 at a rising edge, s1_valid and out_valid SHALL clear to 0; sum_out, carry_out, overflow_out and zero_out SHALL clear to 0.
REQ-030 in_ready SHALL read 1 in the first cycle after reset is released.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats; no stale beat SHALL appear after release.

Configuration
REQ-032 Macro ADDER_SUM_FLAGS_EN SHALL control the flag logic.
REQ-033 With ADDER_SUM_FLAGS_EN defined, carry_out, overflow_out and zero_out SHALL be computed per REQ-019.
REQ-034 Without ADDER_SUM_FLAGS_EN, those three outputs SHALL be constant 0, no flag registers SHALL be instantiated, and sum/handshake behaviour SHALL be unchanged.

Verification (LEN_DATA=32; g/p from a bench prefix model of a,b)
REQ-035 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, carry_out=1, overflow=0, zero=1, out_valid 2 edges after accept.
REQ-036 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, carry_out=0, overflow=1, zero=0.
REQ-037 a=0x12345678, b=0x0F0F0F0F, cin=1 -> sum=0x21436588, carry_out=0, overflow=0.
REQ-038 Drive 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready=0 after 2 beats are held; after release all 4 results emerge in order with none lost.
REQ-039 Assert rst for 1 cycle with both stages full -> out_valid=0 and in_ready=1 next cycle; the next beat is the first output.
REQ-040 Build without ADDER_SUM_FLAGS_EN and run REQ-035 -> sum=0x00000000 and all flags 0.
